// File: rtl/bsg_manycore_eva_xlate_arbiter.sv
// Round-robin arbiter sharing one EVA->NPA translator among endpoint
// request sources, with a one-entry NPA output register.
//
// Ports:
//   clk_i, reset_i                 clock, async active-high reset
//   v_i/eva_i/w_i/data_i/ready_o   per-requester request handshake
//   cfg_v_i/cfg_tgo_*/cfg_dram_*   configuration register load
//   v_o/ready_i + x/y/epa/w/data/src_id   translated packet out
//   err_v_o/err_src_o/err_eva_o/err_count_o   invalid-EVA report
//
// EVA map (32-bit byte address, bits [31:30]):
//   11 host     : dest (0,1), epa = {1, eva[28:2]}
//   10 DRAM     : dram_en=1 -> striped over vcaches by block;
//                 dram_en=0 -> vcaches used as flat block memory
//   01 tile-grp : dest = origin + (eva[29:24], eva[23:18])
//   00 local    : not a remote address, reported as invalid
module bsg_manycore_eva_xlate_arbiter #(
  parameter int num_req_p = 2,
  parameter int data_width_p = 32,
  parameter int addr_width_p = 28,
  parameter int x_cord_width_p = 4,
  parameter int y_cord_width_p = 4,
  parameter int num_tiles_x_p = 4,
  parameter int num_tiles_y_p = 4,
  parameter int vcache_block_size_in_words_p = 8,
  parameter int vcache_size_p = 512,
  parameter int vcache_sets_p = 64,
  parameter int id_width_lp =
    (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
  input  logic clk_i,
  input  logic reset_i,

  input  logic [num_req_p-1:0] v_i,
  input  logic [num_req_p*data_width_p-1:0] eva_i,
  input  logic [num_req_p-1:0] w_i,
  input  logic [num_req_p*data_width_p-1:0] data_i,
  output logic [num_req_p-1:0] ready_o,

  input  logic cfg_v_i,
  input  logic [x_cord_width_p-1:0] cfg_tgo_x_i,
  input  logic [y_cord_width_p-1:0] cfg_tgo_y_i,
  input  logic cfg_dram_enable_i,

  output logic v_o,
  input  logic ready_i,
  output logic [x_cord_width_p-1:0] x_cord_o,
  output logic [y_cord_width_p-1:0] y_cord_o,
  output logic [addr_width_p-1:0] epa_o,
  output logic w_o,
  output logic [data_width_p-1:0] data_o,
  output logic [id_width_lp-1:0] src_id_o,

  output logic err_v_o,
  output logic [id_width_lp-1:0] err_src_o,
  output logic [data_width_p-1:0] err_eva_o,
  output logic [15:0] err_count_o
);

  localparam int lg_blk_lp =
    $clog2(vcache_block_size_in_words_p);
  localparam int lg_tx_lp =
    (num_tiles_x_p > 1) ? $clog2(num_tiles_x_p) : 1;
  // Flat block-memory window per vcache is bounded by both the
  // declared size and the set geometry.
  localparam int geo_words_lp =
    vcache_sets_p * vcache_block_size_in_words_p;
  localparam int vc_words_lp =
    (vcache_size_p < geo_words_lp) ? vcache_size_p : geo_words_lp;
  localparam int lg_vc_lp = $clog2(vc_words_lp);
  localparam logic [y_cord_width_p-1:0] south_y_lp =
    y_cord_width_p'(num_tiles_y_p + 1);
  localparam logic [y_cord_width_p-1:0] host_y_lp =
    y_cord_width_p'(1);

  typedef enum logic {EMPTY, FULL} state_e;
  state_e state_r, state_n;

  logic [x_cord_width_p-1:0] tgo_x_r;
  logic [y_cord_width_p-1:0] tgo_y_r;
  logic dram_en_r;

  logic [id_width_lp-1:0] ptr_r, gnt_id;
  logic any_v, accept, load, drop;

  logic [data_width_p-1:0] g_eva, g_data;
  logic g_w;
  logic [27:0] word;

  logic xl_v;
  logic [x_cord_width_p-1:0] xl_x;
  logic [y_cord_width_p-1:0] xl_y;
  logic [addr_width_p-1:0] xl_epa;

  logic unused_byte;

  // First valid requester scanning upward from ptr_r.
  always_comb begin
    logic [id_width_lp-1:0] idx;
    any_v = 1'b0;
    gnt_id = '0;
    idx = '0;
    for (int i = 0; i < num_req_p; i++) begin
      idx = id_width_lp'((int'(ptr_r) + i) % num_req_p);
      if (!any_v && v_i[idx]) begin
        any_v = 1'b1;
        gnt_id = idx;
      end
    end
  end

  assign accept = any_v & ((state_r == EMPTY) | ready_i);

  always_comb begin
    ready_o = '0;
    if (accept) ready_o[gnt_id] = 1'b1;
  end

  assign g_eva =
    eva_i[int'(gnt_id)*data_width_p +: data_width_p];
  assign g_data =
    data_i[int'(gnt_id)*data_width_p +: data_width_p];
  assign g_w = w_i[gnt_id];
  assign word = g_eva[29:2];
  assign unused_byte = ^g_eva[1:0];

  always_comb begin
    xl_v = 1'b0;
    xl_x = '0;
    xl_y = '0;
    xl_epa = '0;
    unique case (g_eva[31:30])
      2'b11: begin
        xl_v = 1'b1;
        xl_y = host_y_lp;
        xl_epa = addr_width_p'({1'b1, g_eva[28:2]});
      end
      2'b10: begin
        if (dram_en_r) begin
          xl_v = 1'b1;
          xl_x = x_cord_width_p'(word[lg_blk_lp +: lg_tx_lp]);
          xl_y = word[lg_blk_lp+lg_tx_lp] ? south_y_lp : '0;
          xl_epa = addr_width_p'({
            word >> (lg_blk_lp + lg_tx_lp + 1),
            word[lg_blk_lp-1:0]});
        end else begin
          xl_v = (word >> (lg_vc_lp + lg_tx_lp + 1)) == '0;
          xl_x = x_cord_width_p'(word[lg_vc_lp +: lg_tx_lp]);
          xl_y = word[lg_vc_lp+lg_tx_lp] ? south_y_lp : '0;
          xl_epa = addr_width_p'(word[lg_vc_lp-1:0]);
        end
      end
      2'b01: begin
        xl_v = (int'(g_eva[29:24]) < num_tiles_y_p)
             && (int'(g_eva[23:18]) < num_tiles_x_p);
        xl_x = tgo_x_r + g_eva[18 +: x_cord_width_p];
        xl_y = tgo_y_r + g_eva[24 +: y_cord_width_p];
        xl_epa = addr_width_p'(g_eva[17:2]);
      end
      default: xl_v = 1'b0;
    endcase
  end

  assign load = accept & xl_v;
  assign drop = accept & ~xl_v;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_r <= EMPTY;
    else state_r <= state_n;
  end

  always_comb begin
    state_n = state_r;
    unique case (state_r)
      EMPTY: if (load) state_n = FULL;
      FULL: if (ready_i && !load) state_n = EMPTY;
      default: state_n = EMPTY;
    endcase
  end

  always_comb v_o = (state_r == FULL);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      x_cord_o <= '0;
      y_cord_o <= '0;
      epa_o <= '0;
      w_o <= 1'b0;
      data_o <= '0;
      src_id_o <= '0;
    end else if (load) begin
      x_cord_o <= xl_x;
      y_cord_o <= xl_y;
      epa_o <= xl_epa;
      w_o <= g_w;
      data_o <= g_data;
      src_id_o <= gnt_id;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ptr_r <= '0;
    end else if (accept) begin
      ptr_r <= (gnt_id == id_width_lp'(num_req_p-1))
             ? '0 : gnt_id + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      tgo_x_r <= '0;
      tgo_y_r <= '0;
      dram_en_r <= 1'b0;
    end else if (cfg_v_i) begin
      tgo_x_r <= cfg_tgo_x_i;
      tgo_y_r <= cfg_tgo_y_i;
      dram_en_r <= cfg_dram_enable_i;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      err_v_o <= 1'b0;
      err_src_o <= '0;
      err_eva_o <= '0;
      err_count_o <= '0;
    end else begin
      err_v_o <= drop;
      if (drop) begin
        err_src_o <= gnt_id;
        err_eva_o <= g_eva;
        if (err_count_o != 16'hFFFF)
          err_count_o <= err_count_o + 16'd1;
      end
    end
  end

endmodule
